// File: rtl/request_scheduler.sv
// Purpose : latches elevator floor calls, picks the next target floor and presents it to the
//           travel FSM; also runs the door-hold timer and the seconds counter the FSM reads.
// Latency : button edge -> request bit 1 cycle, request bit -> next_stage 1 cycle (2 total when idle).
// Backpressure: next_stage is held until the FSM echoes it on Solicitud_stage with FR_Delay;
//           further calls are queued as request bits meanwhile.
//
// Ports
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   tick_1hz                    one-cycle pulse per second
//   cab_btn, hall_up, hall_dn   floor call buttons (hall_up[3] and hall_dn[0] are unused)
//   door_open_btn/close_btn     door buttons, present only when DOOR_BUTTONS_EN is defined
//   Actual_Stage, UD_Answer     current floor and travel direction from the FSM
//   Delay, FR_Delay             arrival strobe and request-acknowledge strobe from the FSM
//   Solicitud_stage             request echoed back with FR_Delay
//   reset_clock, STOP           seconds-counter clear and FSM idle indication
//   next_stage                  presented request {1, floor}, 3'b000 when none
//   OC_Request, UD_Request      doors held open / departure direction (1 = up)
//   NO_STOP                     work pending while the FSM is idle
//   actual_clock                saturating seconds counter
//
// Build option: define DOOR_BUTTONS_EN to add the door open/close buttons.

module request_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] cab_btn,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
`ifdef DOOR_BUTTONS_EN
    input  logic       door_open_btn,
    input  logic       door_close_btn,
`endif
    input  logic [1:0] Actual_Stage,
    input  logic       UD_Answer,
    input  logic       Delay,
    input  logic       FR_Delay,
    input  logic [2:0] Solicitud_stage,
    input  logic       reset_clock,
    input  logic       STOP,
    output logic [2:0] next_stage,
    output logic       OC_Request,
    output logic       UD_Request,
    output logic       NO_STOP,
    output logic [3:0] actual_clock
);

    // Edge-detect copies of the buttons and of the arrival strobe.
    logic [3:0] cab_q, hup_q, hdn_q;
    logic       delay_q;

    logic [3:0] cab_req, up_req, dn_req;
    logic [2:0] door_cnt;

    logic [3:0] cab_rise, up_rise, dn_rise;
    logic       delay_rise;
    logic [3:0] arr_clr;

    // The top floor has no up call and the ground floor no down call.
    assign cab_rise   = cab_btn & ~cab_q;
    assign up_rise    = hall_up & 4'b0111 & ~hup_q;
    assign dn_rise    = hall_dn & 4'b1110 & ~hdn_q;
    assign delay_rise = Delay & ~delay_q;
    assign arr_clr    = delay_rise ? (4'b0001 << Actual_Stage) : 4'b0000;

    // Door timer controls: a load reloads the 5 s hold, a clear closes immediately.
    logic door_load, door_clr;

`ifdef DOOR_BUTTONS_EN
    logic       open_q, close_q;
    logic [1:0] stage_q;
    logic       open_rise, close_rise;

    // Opening is only honoured while parked: idle FSM and floor unchanged since last cycle.
    assign open_rise  = door_open_btn & ~open_q & STOP & (Actual_Stage == stage_q);
    assign close_rise = door_close_btn & ~close_q;
    assign door_load  = delay_rise | open_rise;
    assign door_clr   = close_rise & ~door_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_q  <= 1'b0;
            close_q <= 1'b0;
            stage_q <= 2'd0;
        end else begin
            open_q  <= door_open_btn;
            close_q <= door_close_btn;
            stage_q <= Actual_Stage;
        end
    end
`else
    assign door_load = delay_rise;
    assign door_clr  = 1'b0;
`endif

    // Target selection: nearest pending floor ahead, else nearest behind.
    logic [3:0] pend;
    logic       up_vld, dn_vld, tgt_vld;
    logic [1:0] up_flr, dn_flr, tgt_flr;

    always_comb begin
        // The current floor is never a target.
        pend   = (cab_req | up_req | dn_req) & ~(4'b0001 << Actual_Stage);
        up_vld = 1'b0;
        up_flr = 2'd0;
        dn_vld = 1'b0;
        dn_flr = 2'd0;
        // Scan downward so the last hit above is the closest one.
        for (int f = 3; f >= 0; f--) begin
            if (pend[f] && (2'(f) > Actual_Stage)) begin
                up_vld = 1'b1;
                up_flr = 2'(f);
            end
        end
        // Scan upward so the last hit below is the closest one.
        for (int f = 0; f <= 3; f++) begin
            if (pend[f] && (2'(f) < Actual_Stage)) begin
                dn_vld = 1'b1;
                dn_flr = 2'(f);
            end
        end
        if (UD_Answer) begin
            tgt_vld = up_vld | dn_vld;
            tgt_flr = up_vld ? up_flr : dn_flr;
        end else begin
            tgt_vld = dn_vld | up_vld;
            tgt_flr = dn_vld ? dn_flr : up_flr;
        end
    end

    // Ack only counts against a presented request, so an idle 3'b000 echo cannot block a load.
    logic ack;
    assign ack = FR_Delay & next_stage[2] & (Solicitud_stage == next_stage);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cab_q        <= 4'd0;
            hup_q        <= 4'd0;
            hdn_q        <= 4'd0;
            delay_q      <= 1'b0;
            cab_req      <= 4'd0;
            up_req       <= 4'd0;
            dn_req       <= 4'd0;
            next_stage   <= 3'd0;
            UD_Request   <= 1'b0;
            NO_STOP      <= 1'b0;
            door_cnt     <= 3'd0;
            OC_Request   <= 1'b0;
            actual_clock <= 4'd0;
        end else begin
            cab_q   <= cab_btn;
            hup_q   <= hall_up;
            hdn_q   <= hall_dn;
            delay_q <= Delay;

            // Arrival clear beats a same-cycle button edge on the same bit.
            cab_req <= (cab_req | cab_rise) & ~arr_clr;
            up_req  <= (up_req | up_rise) & ~(UD_Answer ? arr_clr : 4'b0000);
            dn_req  <= (dn_req | dn_rise) & ~(UD_Answer ? 4'b0000 : arr_clr);

            if (ack)
                next_stage <= 3'd0;
            else if (!next_stage[2] && tgt_vld)
                next_stage <= {1'b1, tgt_flr};

            if (tgt_vld)
                UD_Request <= (tgt_flr > Actual_Stage);

            NO_STOP <= STOP & tgt_vld;

            if (door_load) begin
                door_cnt   <= 3'd5;
                OC_Request <= 1'b1;
            end else if (door_clr) begin
                door_cnt   <= 3'd0;
                OC_Request <= 1'b0;
            end else if (tick_1hz && (door_cnt != 3'd0)) begin
                door_cnt <= door_cnt - 3'd1;
                if (door_cnt == 3'd1)
                    OC_Request <= 1'b0;
            end

            if (reset_clock)
                actual_clock <= 4'd0;
            else if (tick_1hz && (actual_clock != 4'd15))
                actual_clock <= actual_clock + 4'd1;
        end
    end

endmodule

// File: tb/tb_request_scheduler.sv
// Purpose : directed-vector bench for request_scheduler with hand-computed expectations.
// Latency : inputs change 1 time unit after a rising edge, outputs are read at the same point.
// Backpressure: the FSM side is modelled by driving FR_Delay/Solicitud_stage directly.

module tb_request_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [3:0] cab_btn = 4'd0;
    logic [3:0] hall_up = 4'd0;
    logic [3:0] hall_dn = 4'd0;
`ifdef DOOR_BUTTONS_EN
    logic       door_open_btn = 1'b0;
    logic       door_close_btn = 1'b0;
`endif
    logic [1:0] Actual_Stage = 2'd0;
    logic       UD_Answer = 1'b0;
    logic       Delay = 1'b0;
    logic       FR_Delay = 1'b0;
    logic [2:0] Solicitud_stage = 3'd0;
    logic       reset_clock = 1'b0;
    logic       STOP = 1'b0;
    logic [2:0] next_stage;
    logic       OC_Request;
    logic       UD_Request;
    logic       NO_STOP;
    logic [3:0] actual_clock;

    int n_cmp = 0;
    int n_bad = 0;

    request_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .tick_1hz        (tick_1hz),
        .cab_btn         (cab_btn),
        .hall_up         (hall_up),
        .hall_dn         (hall_dn),
`ifdef DOOR_BUTTONS_EN
        .door_open_btn   (door_open_btn),
        .door_close_btn  (door_close_btn),
`endif
        .Actual_Stage    (Actual_Stage),
        .UD_Answer       (UD_Answer),
        .Delay           (Delay),
        .FR_Delay        (FR_Delay),
        .Solicitud_stage (Solicitud_stage),
        .reset_clock     (reset_clock),
        .STOP            (STOP),
        .next_stage      (next_stage),
        .OC_Request      (OC_Request),
        .UD_Request      (UD_Request),
        .NO_STOP         (NO_STOP),
        .actual_clock    (actual_clock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One tick_1hz pulse followed by one quiet cycle.
    task automatic tick;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ns",    int'(next_stage),   0);
        check("rst_oc",    int'(OC_Request),   0);
        check("rst_ud",    int'(UD_Request),   0);
        check("rst_nostop", int'(NO_STOP),     0);
        check("rst_clock", int'(actual_clock), 0);
        reset = 1'b0;
        step();

        // Cab call to floor 2 from floor 0 going up: 2 cycles to next_stage
        Actual_Stage = 2'd0;
        UD_Answer    = 1'b1;
        STOP         = 1'b1;
        cab_btn      = 4'b0100;
        step();
        cab_btn = 4'b0000;
        check("press_lat1_ns", int'(next_stage), 0);
        step();
        check("press_ns",     int'(next_stage), 6);
        check("press_ud",     int'(UD_Request), 1);
        check("press_nostop", int'(NO_STOP),    1);
        STOP = 1'b0;
        step();
        check("nostop_drop", int'(NO_STOP), 0);

        // Mismatched acknowledge is ignored, matching one clears then reloads
        FR_Delay        = 1'b1;
        Solicitud_stage = 3'b101;
        step();
        check("bad_ack_ns", int'(next_stage), 6);
        Solicitud_stage = 3'b110;
        step();
        FR_Delay = 1'b0;
        check("ack_ns", int'(next_stage), 0);
        step();
        check("reload_ns", int'(next_stage), 6);

        // Reset mid-operation discards pending work; nothing comes back after release
        reset = 1'b1;
        #1;
        check("async_rst_ns", int'(next_stage), 0);
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("no_replay_ns", int'(next_stage), 0);

        // Unused hall bits and a call at the current floor give no target
        Actual_Stage = 2'd1;
        hall_up      = 4'b1000;
        hall_dn      = 4'b0001;
        step();
        hall_up = 4'b0000;
        hall_dn = 4'b0000;
        step();
        step();
        check("ignored_bits_ns", int'(next_stage), 0);
        cab_btn = 4'b0010;
        step();
        cab_btn = 4'b0000;
        step();
        step();
        check("own_floor_ns", int'(next_stage), 0);

        // Pending 0 and 3 from floor 1: up picks 3, down picks 0
        UD_Answer = 1'b1;
        cab_btn   = 4'b0001;
        hall_dn   = 4'b1000;
        step();
        cab_btn = 4'b0000;
        hall_dn = 4'b0000;
        step();
        check("dir_up_ns", int'(next_stage), 7);
        check("dir_up_ud", int'(UD_Request), 1);
        FR_Delay        = 1'b1;
        Solicitud_stage = 3'b111;
        UD_Answer       = 1'b0;
        step();
        FR_Delay = 1'b0;
        check("dir_ack_ns", int'(next_stage), 0);
        step();
        check("dir_dn_ns", int'(next_stage), 4);
        check("dir_dn_ud", int'(UD_Request), 0);

        // Arrival at floor 2 going down: clear beats same-cycle hall_dn[2], door timer runs 5 ticks
        reset = 1'b1;
        step();
        reset        = 1'b0;
        Actual_Stage = 2'd2;
        UD_Answer    = 1'b0;
        hall_dn      = 4'b0100;
        step();
        hall_dn = 4'b0000;
        step();
        check("dn2_set", int'(dut.dn_req[2]), 1);
        Delay   = 1'b1;
        hall_dn = 4'b0100;
        step();
        Delay   = 1'b0;
        hall_dn = 4'b0000;
        check("dn2_clear_wins", int'(dut.dn_req[2]), 0);
        check("door_open",      int'(OC_Request),    1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("door_tick%0d", i), int'(OC_Request), (i < 5) ? 1 : 0);
        end

        // A second arrival while open restarts the full 5 s hold
        Delay = 1'b1;
        step();
        Delay = 1'b0;
        tick();
        tick();
        Delay = 1'b1;
        step();
        Delay = 1'b0;
        check("door_reload_cnt", int'(dut.door_cnt), 5);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("reload_tick%0d", i), int'(OC_Request), (i < 5) ? 1 : 0);
        end

        // Seconds counter: clear wins over tick, then saturate at 15
        tick();
        reset_clock = 1'b1;
        tick_1hz    = 1'b1;
        step();
        reset_clock = 1'b0;
        tick_1hz    = 1'b0;
        check("clk_clear", int'(actual_clock), 0);
        tick();
        check("clk_one", int'(actual_clock), 1);
        for (int i = 0; i < 19; i++) tick();
        check("clk_sat", int'(actual_clock), 15);
        tick();
        check("clk_hold", int'(actual_clock), 15);

`ifdef DOOR_BUTTONS_EN
        // Close button shuts an open door; open+close together keeps it open
        Delay = 1'b1;
        step();
        Delay = 1'b0;
        check("btn_pre_open", int'(OC_Request), 1);
        door_close_btn = 1'b1;
        step();
        door_close_btn = 1'b0;
        check("btn_close", int'(OC_Request), 0);
        STOP           = 1'b1;
        door_open_btn  = 1'b1;
        door_close_btn = 1'b1;
        step();
        door_open_btn  = 1'b0;
        door_close_btn = 1'b0;
        check("btn_both_oc",  int'(OC_Request),    1);
        check("btn_both_cnt", int'(dut.door_cnt),  5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/request_scheduler.md
REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  system clock; all state is updated on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-005 cab_btn  in  4  car-panel floor buttons for floors 0-3, active-high level.
REQ-006 hall_up  in  4  hall up-call buttons; bit 3 is ignored.
REQ-007 hall_dn  in  4  hall down-call buttons; bit 0 is ignored.
REQ-008 door_open_btn, door_close_btn  in  1 each  door buttons; present only with DOOR_BUTTONS_EN.
REQ-009 Actual_Stage  in  2  current floor reported by the FSM.
REQ-010 UD_Answer  in  1  FSM direction: 1 = up, 0 = down.
REQ-011 Delay  in  1  FSM arrival strobe.
REQ-012 FR_Delay  in  1  FSM acknowledge strobe for a presented request.
REQ-013 Solicitud_stage  in  3  request echoed back by the FSM with FR_Delay.
REQ-014 reset_clock  in  1  FSM request to clear the seconds counter.
REQ-015 STOP  in  1  FSM idle indication.
REQ-016 next_stage  out  3  presented request, encoded {1, floor}; 3'b000 = none.
REQ-017 OC_Request  out  1  doors held open.
REQ-018 UD_Request  out  1  departure direction toward the target: 1 = up.
REQ-019 NO_STOP  out  1  work pending while the FSM is idle.
REQ-020 actual_clock  out  4  seconds counter for the FSM.

Function
REQ-021 Each button input SHALL be rising-edge detected against a one-cycle registered copy of itself; an edge sets the matching bit in the cab_req, up_req or dn_req register at the next clock edge.
REQ-022 On the rising edge of Delay, the block SHALL clear cab_req[Actual_Stage] together with up_req[Actual_Stage] when UD_Answer=1, or dn_req[Actual_Stage] when UD_Answer=0.
REQ-023 When a button edge and the arrival clear hit the same bit in the same cycle, the clear SHALL win.
REQ-024 A floor is pending when it has any of cab_req, up_req or dn_req set.
REQ-025 Target selection SHALL pick the nearest pending floor strictly ahead in the UD_Answer direction; if there is none, the nearest pending floor in the opposite direction; if there is none, no target.
REQ-026 Actual_Stage SHALL never be selected as a target.
REQ-027 The next_stage register SHALL load {1, target} only when it is 3'b000 and a target exists, giving 2 cycles from button press to next_stage when the scheduler is idle.
REQ-028 Once loaded, next_stage SHALL stay stable until FR_Delay=1 with Solicitud_stage equal to next_stage.
REQ-029 When that acknowledge occurs, next_stage SHALL go to 3'b000 in the following cycle and reload one cycle later if a target exists.
REQ-030 A mismatched Solicitud_stage SHALL be ignored.
REQ-031 UD_Request SHALL be registered as 1 when the selected target is above Actual_Stage, and 0 otherwise.
REQ-032 With no target, UD_Request SHALL hold its last value.
REQ-033 NO_STOP SHALL be registered as STOP AND (a target exists); it drops one cycle after STOP falls.
REQ-034 Door timer: the rising edge of Delay SHALL set OC_Request=1 and load door_cnt=5.
REQ-035 Each tick_1hz SHALL decrement door_cnt while it is nonzero; OC_Request SHALL clear the cycle door_cnt reaches 0.
REQ-036 A Delay edge that arrives while OC_Request=1 SHALL reload door_cnt=5.
REQ-037 The seconds counter actual_clock SHALL read 0 while reset_clock=1, increment on tick_1hz otherwise, and saturate at 15.
REQ-038 If reset_clock and tick_1hz occur in the same cycle, reset_clock SHALL win.

Reset
REQ-039 Asserting reset SHALL asynchronously clear all request bits, the edge-detect registers, door_cnt, next_stage, OC_Request, UD_Request, NO_STOP and actual_clock to 0.
REQ-040 Reset asserted mid-operation SHALL discard all pending requests; no request SHALL be replayed after reset is released.

Configuration
REQ-041 Macro DOOR_BUTTONS_EN SHALL select door-button support.
REQ-042 With DOOR_BUTTONS_EN defined, a door_open_btn edge SHALL reload door_cnt=5 and set OC_Request when Actual_Stage is stable and STOP=1.
REQ-043 With DOOR_BUTTONS_EN defined, a door_close_btn edge SHALL clear door_cnt and OC_Request in the next cycle, and open wins if both edges occur in the same cycle.
REQ-044 With DOOR_BUTTONS_EN undefined, both door-button ports SHALL be absent and the door timer SHALL be driven only by Delay.

Verification
REQ-045 Reset, then cab_btn[2] pulse with Actual_Stage=0 and UD_Answer=1 -> next_stage=3'b110 exactly 2 cycles later, UD_Request=1, NO_STOP=1 while STOP=1.
REQ-046 next_stage=3'b110 presented, then FR_Delay with Solicitud_stage=3'b101 -> next_stage unchanged; FR_Delay with Solicitud_stage=3'b110 -> next_stage 3'b000 in the next cycle.
REQ-047 Pending floors 0 and 3, Actual_Stage=1, UD_Answer=1 -> next_stage=3'b111; with UD_Answer=0 instead -> next_stage=3'b100.
REQ-048 Delay pulse at floor 2 with UD_Answer=0 and dn_req[2] set, hall_dn[2] pressed in the same cycle -> dn_req[2]=0, OC_Request=1, OC_Request falls after 5 tick_1hz pulses.
REQ-049 reset_clock=1 together with tick_1hz -> actual_clock=0; then 20 ticks -> actual_clock=15 and held.
REQ-050 With DOOR_BUTTONS_EN defined, press door_close_btn while OC_Request=1 -> OC_Request=0 next cycle; press open and close together -> OC_Request=1 and door_cnt=5.
